// File: rtl/sarray_ctrl.sv
// Sequencer for the systolic array: feeds K paired operand beats onto the left/top
// edges, waits out the array propagation delay, then holds store-C until DIM results drain.
module sarray_ctrl #(
  parameter int CNT_W     = 8,
  parameter int PREC_W    = 2,
  parameter int LOAD_W    = 512,
  parameter int DIM       = 64,
  parameter int DRAIN_CYC = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshakes (cmd, a, b): a transfer happens in a cycle where valid and ready are both
  // high at the rising edge; ready may depend combinationally on valid, and a and b
  // only ever transfer together.
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CNT_W-1:0]  cmd_k_i,
  input  logic              cmd_acc_i,
  input  logic              cmd_type_i,
  input  logic [PREC_W-1:0] cmd_prec_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [LOAD_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [LOAD_W-1:0] b_data_i,
  output logic              left_in_valid_o,
  output logic [CNT_W-1:0]  left_in_cnt_o,
  output logic              left_in_type_o,
  output logic [PREC_W-1:0] left_in_precision_o,
  output logic [LOAD_W-1:0] left_in_data_o,
  output logic              top_in_valid_o,
  output logic              top_in_acc_o,
  output logic [CNT_W-1:0]  top_in_cnt_o,
  output logic [LOAD_W-1:0] top_in_data_o,
  output logic              post_storec_valid_o,
  input  logic              bot_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        state_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam int STORE_W = $clog2(DIM) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [STORE_W-1:0] STORE_LAST = STORE_W'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   k_q;
  logic               acc_q;
  logic               type_q;
  logic [PREC_W-1:0]  prec_q;
  logic [CNT_W-1:0]   beat_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [STORE_W-1:0] store_q;
  logic               err_q;

  logic cmd_fire;
  logic feed_beat;
  logic last_beat;
  logic drain_end;
  logic store_end;
  logic stray_bot;

  assign cmd_fire  = (state_q == S_IDLE) && cmd_valid_i;
  assign feed_beat = (state_q == S_FEED) && a_valid_i && b_valid_i;
  // k_q is non-zero whenever FEED is entered, so k_q-1 never underflows here.
  assign last_beat = feed_beat && (beat_q == (k_q - CNT_W'(1)));
  assign drain_end = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);
  assign store_end = (state_q == S_STORE) && bot_valid_i && (store_q == STORE_LAST);
  assign stray_bot = bot_valid_i && (state_q != S_STORE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = (cmd_k_i == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (store_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready_o         = 1'b0;
    a_ready_o           = 1'b0;
    b_ready_o           = 1'b0;
    post_storec_valid_o = 1'b0;
    done_o              = 1'b0;
    busy_o              = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_FEED: begin
        a_ready_o = feed_beat;
        b_ready_o = feed_beat;
      end
      S_DRAIN: begin
      end
      S_STORE: begin
        post_storec_valid_o = 1'b1;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_o = state_q;

  // Command attributes stay constant for the whole command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      acc_q  <= 1'b0;
      type_q <= 1'b0;
      prec_q <= '0;
    end else if (cmd_fire) begin
      k_q    <= cmd_k_i;
      acc_q  <= cmd_acc_i;
      type_q <= cmd_type_i;
      prec_q <= cmd_prec_i;
    end
  end

  // Beat, drain and store counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      drain_q <= '0;
      store_q <= '0;
    end else if (cmd_fire) begin
      beat_q  <= '0;
      drain_q <= '0;
      store_q <= '0;
    end else begin
      if (feed_beat) begin
        beat_q <= beat_q + CNT_W'(1);
      end
      if (state_q == S_DRAIN) begin
        drain_q <= drain_q + DRAIN_W'(1);
      end
      if ((state_q == S_STORE) && bot_valid_i) begin
        store_q <= store_q + STORE_W'(1);
      end
    end
  end

  // A stray result beat in the same cycle as an accept still counts as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (stray_bot) begin
      err_q <= 1'b1;
    end else if (cmd_fire) begin
      err_q <= 1'b0;
    end
  end

  assign err_o = err_q;

  // Edge registers: valid pulses per beat, data/cnt hold between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_in_valid_o <= 1'b0;
      top_in_valid_o  <= 1'b0;
      left_in_cnt_o   <= '0;
      top_in_cnt_o    <= '0;
      left_in_data_o  <= '0;
      top_in_data_o   <= '0;
    end else begin
      left_in_valid_o <= feed_beat;
      top_in_valid_o  <= feed_beat;
      if (feed_beat) begin
        left_in_cnt_o  <= beat_q;
        top_in_cnt_o   <= beat_q;
        left_in_data_o <= a_data_i;
        top_in_data_o  <= b_data_i;
      end
    end
  end

  assign left_in_type_o      = type_q;
  assign left_in_precision_o = prec_q;
  assign top_in_acc_o        = acc_q;

endmodule

// File: tb/tb_sarray_ctrl.sv
// Directed-sequence bench for sarray_ctrl with random operand traffic checked
// against a cycle-count / expected-queue model of the command lifecycle.
module tb_sarray_ctrl;

  localparam int CNT_W     = 8;
  localparam int PREC_W    = 2;
  localparam int LOAD_W    = 512;
  localparam int DIM       = 64;
  localparam int DRAIN_CYC = 127;
  localparam int W         = LOAD_W;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_k;
  logic              cmd_acc;
  logic              cmd_type;
  logic [PREC_W-1:0] cmd_prec;
  logic              a_valid, a_ready;
  logic [LOAD_W-1:0] a_data;
  logic              b_valid, b_ready;
  logic [LOAD_W-1:0] b_data;
  logic              left_valid;
  logic [CNT_W-1:0]  left_cnt;
  logic              left_type;
  logic [PREC_W-1:0] left_prec;
  logic [LOAD_W-1:0] left_data;
  logic              top_valid;
  logic              top_acc;
  logic [CNT_W-1:0]  top_cnt;
  logic [LOAD_W-1:0] top_data;
  logic              storec;
  logic              bot_valid;
  logic              busy, done, err;
  logic [2:0]        state_dbg;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     exp_b_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  logic [W-1:0]     last_a, last_b;

  sarray_ctrl #(
    .CNT_W(CNT_W), .PREC_W(PREC_W), .LOAD_W(LOAD_W), .DIM(DIM), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_k_i(cmd_k),
    .cmd_acc_i(cmd_acc), .cmd_type_i(cmd_type), .cmd_prec_i(cmd_prec),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
    .left_in_valid_o(left_valid), .left_in_cnt_o(left_cnt), .left_in_type_o(left_type),
    .left_in_precision_o(left_prec), .left_in_data_o(left_data),
    .top_in_valid_o(top_valid), .top_in_acc_o(top_acc), .top_in_cnt_o(top_cnt),
    .top_in_data_o(top_data),
    .post_storec_valid_o(storec), .bot_valid_i(bot_valid),
    .busy_o(busy), .done_o(done), .err_o(err), .state_o(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_left_valid"}, W'(left_valid), '0);
    check({tag, "_top_valid"}, W'(top_valid), '0);
    check({tag, "_left_cnt"}, W'(left_cnt), '0);
    check({tag, "_top_cnt"}, W'(top_cnt), '0);
    check({tag, "_left_data"}, left_data, '0);
    check({tag, "_top_data"}, top_data, '0);
    check({tag, "_attr"}, W'({left_type, left_prec, top_acc}), '0);
    check({tag, "_storec"}, W'(storec), '0);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_done"}, W'(done), '0);
    check({tag, "_err"}, W'(err), '0);
    check({tag, "_cmd_ready"}, W'(cmd_ready), W'(1));
  endtask

  // One full command; the model is: beat j carries cnt j and the j-th accepted pair,
  // store-C starts DRAIN_CYC cycles after the last edge beat, done follows the DIM-th result.
  task automatic run_cmd(input int k, input logic acc, input logic typ,
                         input logic [PREC_W-1:0] prec, input bit stall, input bit stray);
    int  sent;
    int  n;
    logic hs;
    cmd_valid = 1'b1;
    cmd_k     = CNT_W'(k);
    cmd_acc   = acc;
    cmd_type  = typ;
    cmd_prec  = prec;
    #1;
    check("cmd_ready_before_accept", W'(cmd_ready), W'(1));
    tick();
    cmd_valid = 1'b0;
    check("err_cleared_on_accept", W'(err), '0);
    if (k == 0) begin
      check("k0_done", W'(done), W'(1));
      check("k0_edges", W'({left_valid, top_valid, storec}), '0);
      tick();
      check("k0_done_drop", W'(done), '0);
      check("k0_cmd_ready", W'(cmd_ready), W'(1));
      return;
    end
    check("busy_after_accept", W'(busy), W'(1));
    check("cmd_ready_busy", W'(cmd_ready), '0);

    sent = 0;
    n = 0;
    while (sent < k && n < 2000) begin
      a_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_valid = stall ? n[0] : 1'b1;
      a_data  = rand_word();
      b_data  = rand_word();
      hs = a_valid & b_valid;
      #1;
      check("a_ready", W'(a_ready), W'(hs));
      check("b_ready", W'(b_ready), W'(hs));
      if (hs) begin
        exp_q.push_back(a_data);
        exp_b_q.push_back(b_data);
        exp_cnt_q.push_back(CNT_W'(sent));
      end
      tick();
      n++;
      check("left_valid", W'(left_valid), W'(hs));
      check("top_valid", W'(top_valid), W'(hs));
      if (hs) begin
        last_a = exp_q.pop_front();
        last_b = exp_b_q.pop_front();
        check("left_cnt", W'(left_cnt), W'(exp_cnt_q[0]));
        check("top_cnt", W'(top_cnt), W'(exp_cnt_q.pop_front()));
        check("left_data", left_data, last_a);
        check("top_data", top_data, last_b);
        check("left_type", W'(left_type), W'(typ));
        check("left_prec", W'(left_prec), W'(prec));
        check("top_acc", W'(top_acc), W'(acc));
        sent++;
      end else begin
        check("left_data_hold", left_data, last_a);
        check("top_data_hold", top_data, last_b);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("feed_beats", W'(sent), W'(k));

    n = 0;
    while (!storec && n < 400) begin
      if (stray && n == 20) bot_valid = 1'b1;
      tick();
      bot_valid = 1'b0;
      n++;
      check("drain_no_edge", W'(left_valid | top_valid | done), '0);
    end
    check("drain_length", W'(n), W'(DRAIN_CYC));
    check("err_after_drain", W'(err), W'(stray));

    for (int i = 0; i < DIM; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        check("storec_gap", W'(storec), W'(1));
      end
      if (i == DIM - 1) check("done_before_last", W'(done), '0);
      bot_valid = 1'b1;
      tick();
      bot_valid = 1'b0;
      if (i < DIM - 1) check("storec_held", W'(storec), W'(1));
    end
    check("done_pulse", W'(done), W'(1));
    check("storec_drop", W'(storec), '0);
    check("cmd_ready_in_done", W'(cmd_ready), '0);
    tick();
    check("done_drop", W'(done), '0);
    check("cmd_ready_after_done", W'(cmd_ready), W'(1));
    check("busy_after_done", W'(busy), '0);
    check("err_sticky", W'(err), W'(stray));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_k     = '0;
    cmd_acc   = 1'b0;
    cmd_type  = 1'b0;
    cmd_prec  = '0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    bot_valid = 1'b0;
    last_a    = '0;
    last_b    = '0;

    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("idle_after_release", W'(cmd_ready), W'(1));

    // Basic, always-valid streams
    run_cmd(4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    // b stream toggling with attributes set
    run_cmd(3, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    // Stray result beat during drain
    run_cmd(5, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    // Zero-length command also clears the sticky error
    run_cmd(0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    // Random commands
    for (int r = 0; r < 3; r++) begin
      run_cmd($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              PREC_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a feed
    cmd_valid = 1'b1;
    cmd_k     = CNT_W'(6);
    cmd_acc   = 1'b1;
    cmd_type  = 1'b1;
    cmd_prec  = 2'd3;
    tick();
    cmd_valid = 1'b0;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = rand_word();
    b_data    = rand_word();
    tick();
    tick();
    check("midfeed_active", W'(left_valid), W'(1));
    cmd_valid = 1'b1;
    #1;
    check("cmd_not_ready_in_feed", W'(cmd_ready), '0);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("async_reset");
    check("a_ready_in_reset", W'(a_ready), '0);
    tick();
    check_idle_outputs("reset_held");
    cmd_valid = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("idle_after_midfeed_reset", W'(cmd_ready), W'(1));
    check("no_done_after_reset", W'(done), '0);
    last_a = '0;
    last_b = '0;
    run_cmd(2, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
